// File: rtl/cla_nibble_seq_adder.sv
// Sequential wide adder/subtractor built around one 4-bit carry-lookahead
// adder. Each clock handles one nibble, starting with the least-significant
// nibble. The carry between nibbles is kept in a register. Operands come in
// and results go out over valid/ready handshakes.

// 4-bit carry-lookahead adder. c[0] is the carry-in and c[4] the carry-out.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic [4:0] c
);
    logic [3:0] g;
    logic [3:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is computed straight from generate/propagate terms, so no carry waits on the one below it.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c[3:0];
endmodule

module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;

    logic [IDX_W+1:0] base;
    logic [3:0]       nib_s;
    logic [4:0]       nib_c;

    // Bit offset of the nibble being processed in this cycle.
    assign base = {idx, 2'b00};

    cla u_cla (
        .a   (a_reg[base +: 4]),
        .b   (b_reg[base +: 4]),
        .cin (carry_reg),
        .s   (nib_s),
        .c   (nib_c)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Control FSM, operand capture and per-nibble result update.
    // NOTE: all state is updated with non-blocking assignments. Every register then samples values from before the edge, whatever order the statements run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is done as A + ~B + ~borrow.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? ~cin : cin;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: 4] <= nib_s;
                    carry_reg      <= nib_c[4];
                    if (idx == LAST) begin
                        cout  <= nib_c[4];
                        ovf   <= nib_c[4] ^ nib_c[3];
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Bench for cla_nibble_seq_adder with WIDTH=16. It covers directed vectors,
// randomized operations checked against an arithmetic model, backpressure,
// reset during an operation and back-to-back throughput.
module tb_cla_nibble_seq_adder;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    cla_nibble_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         sv;
        logic         cv;
        logic [W-1:0] es;
        logic         eco;
        logic         eov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed and unsigned integer arithmetic on whole operands.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic sv, input logic cv,
                                  output logic [W-1:0] s, output logic co, output logic ov);
        int ua, ub, sa, sb, ut, st;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (!sv) begin
            ut = ua + ub + int'(cv);
            st = sa + sb + int'(cv);
            co = (ut > 65535);
        end else begin
            ut = ua - ub - int'(cv);
            st = sa - sb - int'(cv);
            co = (ut >= 0);
        end
        s  = ut[W-1:0];
        ov = (st > 32767) || (st < -32768);
    endfunction

    // Wait (bounded) for in_ready, then present one operation for a single accept edge.
    task automatic start_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sv, input logic cv);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, " ready"}, 32'(in_ready), 32'd1);
        a = av; b = bv; sub = sv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Inputs are ignored while busy, so put junk on them.
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 20) begin
            rdy_seen |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic cv,
                          input logic [W-1:0] es, input logic eco, input logic eov);
        int lat;
        logic rdy_seen;
        start_op(name, av, bv, sv, cv);
        wait_done(lat, rdy_seen);
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " in_ready low while busy"}, 32'(rdy_seen), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd1);
        check({name, " sum"}, 32'(sum), 32'(es));
        check({name, " cout"}, 32'(cout), 32'(eco));
        check({name, " ovf"}, 32'(ovf), 32'(eov));
        release_result();
    endtask

    vec_t vecs[6];

    initial begin
        logic [W-1:0] es, hold_s, ra, rb;
        logic         eco, eov, hold_c, hold_o, rs, rc;
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_b[3];
        int           acc_cyc[3];
        int           k_acc, k_done, cyc, lat;
        logic         acc, rdy_seen;

        vecs[0] = '{"basic add",    16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{"full ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"pos overflow", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"sub neg",      16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{"sub overflow", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{"sub borrowin", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        // An out_ready pulse while idle does nothing.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle out_ready no effect", 32'({in_ready, out_valid, busy}), 32'b100);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].name, vecs[i].av, vecs[i].bv, vecs[i].sv, vecs[i].cv,
                   vecs[i].es, vecs[i].eco, vecs[i].eov);
        end

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra = 16'h0000; rb = 16'h7FFF; rs = 1'b1; rc = 1'b1; end
            if (i == 1) begin ra = 16'h8000; rb = 16'h0000; rs = 1'b1; rc = 1'b1; end
            model(ra, rb, rs, rc, es, eco, eov);
            run_op($sformatf("random %0d", i), ra, rb, rs, rc, es, eco, eov);
        end

        // Backpressure: DONE holds its result while new requests are driven.
        start_op("bp", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        wait_done(lat, rdy_seen);
        check("bp reached done", 32'(out_valid), 32'd1);
        hold_s = sum; hold_c = cout; hold_o = ovf;
        check("bp held sum value", 32'(hold_s), 32'h2233);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            check("bp stable", 32'({sum, cout, ovf}), 32'({hold_s, hold_c, hold_o}));
            check("bp no accept", 32'({in_ready, out_valid}), 32'b01);
        end
        a = 16'h0100; b = 16'h0022; sub = 1'b0; cin = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp back to idle", 32'({in_ready, out_valid, busy}), 32'b100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next accepted", 32'(busy), 32'd1);
        wait_done(lat, rdy_seen);
        check("bp next latency", 32'(lat), 32'd4);
        check("bp next sum", 32'(sum), 32'h0122);
        release_result();

        // Asynchronous reset while the third nibble is in progress.
        start_op("rst", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst mid-run busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op("after reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Back-to-back operations with in_valid and out_ready held high.
        bb_a[0] = 16'hABCD; bb_b[0] = 16'h1111;
        bb_a[1] = 16'h0F0F; bb_b[1] = 16'hF0F1;
        bb_a[2] = 16'h4000; bb_b[2] = 16'hC001;
        k_acc = 0; k_done = 0; cyc = 0;
        a = bb_a[0]; b = bb_b[0]; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        while (k_done < 3 && cyc < 60) begin
            acc = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc && k_acc < 3) begin
                acc_cyc[k_acc] = cyc;
                k_acc++;
                if (k_acc < 3) begin
                    a = bb_a[k_acc]; b = bb_b[k_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                model(bb_a[k_done], bb_b[k_done], 1'b0, 1'b0, es, eco, eov);
                check($sformatf("b2b %0d result", k_done), 32'({sum, cout, ovf}), 32'({es, eco, eov}));
                k_done++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b completed", 32'(k_done), 32'd3);
        check("b2b accepts", 32'(k_acc), 32'd3);
        if (k_acc == 3) begin
            check("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
            check("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
